// File: rtl/pad_io_pkg.sv
// Shared types for the pad I/O controller: FSM state encoding, pull_sel
// codes and the pull_sel -> active-low pull enable decode.
package pad_io_pkg;

  typedef enum logic [1:0] {
    ST_IN,
    ST_TURN_OUT,
    ST_OUT,
    ST_TURN_IN
  } pad_state_e;

  typedef logic [1:0] pull_sel_t;

  localparam pull_sel_t PULL_NONE     = 2'b00;
  localparam pull_sel_t PULL_UP       = 2'b01;
  localparam pull_sel_t PULL_DOWN     = 2'b10;
  localparam pull_sel_t PULL_NONE_ALT = 2'b11;

  // Active-low pad-cell pull enables.
  typedef struct packed {
    logic puen;
    logic pden;
  } pull_en_t;

  // Only one of the two enables can ever be low; every other code releases both.
  function automatic pull_en_t pull_decode(input pull_sel_t sel);
    pull_en_t p;
    p = '{puen: 1'b1, pden: 1'b1};
    case (sel)
      PULL_UP:   p.puen = 1'b0;
      PULL_DOWN: p.pden = 1'b0;
      default:   p = '{puen: 1'b1, pden: 1'b1};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pad_io_ctrl_if.sv
// Core/pad-cell signal bundle of the pad I/O controller.
// master: core plus pad environment (drives requests and Y).
// slave : the controller itself.
interface pad_io_ctrl_if;
  import pad_io_pkg::*;

  logic      dir_req;
  logic      dout;
  pull_sel_t pull_sel;
  logic      A;
  logic      EN;
  logic      PUEN;
  logic      PDEN;
  logic      PI;
  logic      Y;
  logic      din;
  logic      din_valid;
  logic      rise;
  logic      fall;
  logic      busy;

  modport master (
    output dir_req, dout, pull_sel, Y,
    input  A, EN, PUEN, PDEN, PI, din, din_valid, rise, fall, busy
  );

  modport slave (
    input  dir_req, dout, pull_sel, Y,
    output A, EN, PUEN, PDEN, PI, din, din_valid, rise, fall, busy
  );

endinterface

// File: rtl/pad_in_filter.sv
// Pad receive path: 2-flop synchronizer for the asynchronous Y input,
// optionally followed by a debounce filter (build with PAD_DEBOUNCE_EN).
// With the filter, din only follows the synchronized value after it has
// differed from din for 2**DEB_W-1 consecutive cycles while active is high.
module pad_in_filter #(
  parameter int unsigned DEB_W = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic y,
  input  logic active,
  output logic din
);

  logic [1:0] sync_q;

  // Two-stage synchronizer, cleared by reset.
  // NOTE: non-blocking assignments let both flops sample their pre-edge
  // inputs; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge CLK) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[0], y};
  end

`ifdef PAD_DEBOUNCE_EN
  // Counter value seen on the last of the 2**DEB_W-1 stable cycles.
  localparam int unsigned LAST = (1 << DEB_W) - 2;

  logic [DEB_W-1:0] cnt_q;
  logic             din_q;

  // Count consecutive cycles the synchronized value disagrees with din;
  // any return to din or leaving input mode restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      din_q <= 1'b0;
    end else if (!active || (sync_q[1] == din_q)) begin
      cnt_q <= '0;
    end else if (cnt_q == DEB_W'(LAST)) begin
      din_q <= sync_q[1];
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign din = din_q;
`else
  // Filter bypassed: DEB_W and active only reach this tie-off.
  logic [DEB_W:0] unused_cfg;
  assign unused_cfg = {{DEB_W{1'b0}}, active};

  assign din = sync_q[1];
`endif

endmodule

// File: rtl/pad_io_ctrl.sv
// Bidirectional pad controller: sequences direction changes through
// turnaround states so the pad is never driven while pulls are active,
// drives the active-low pad-cell enables and conditions the receive path.
// Optional debounce on the receive path: define PAD_DEBOUNCE_EN.
module pad_io_ctrl
  import pad_io_pkg::*;
#(
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned DEB_W    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  pad_io_ctrl_if.slave  pad
);

  pad_state_e state;
  logic [3:0] turn_cnt;
  logic       fill_q;
  logic       a_q, en_q, puen_q, pden_q, valid_q, busy_q;
  logic       din_w, din_d, valid_d;
  pull_en_t   pull_nxt;

  assign pull_nxt = pull_decode(pad.pull_sel);

  // Direction FSM with registered pad-cell controls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IN;
      turn_cnt <= '0;
      fill_q   <= 1'b0;
      a_q      <= 1'b0;
      en_q     <= 1'b1;
      puen_q   <= 1'b1;
      pden_q   <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        ST_IN: begin
          if (pad.dir_req) begin
            // Release pulls a cycle before the driver turns on.
            state   <= ST_TURN_OUT;
            busy_q  <= 1'b1;
            puen_q  <= 1'b1;
            pden_q  <= 1'b1;
            valid_q <= 1'b0;
          end else begin
            puen_q <= pull_nxt.puen;
            pden_q <= pull_nxt.pden;
            // din becomes trustworthy once the synchronizer has refilled.
            if (!valid_q) begin
              if (fill_q) valid_q <= 1'b1;
              else        fill_q  <= 1'b1;
            end
          end
        end
        ST_TURN_OUT: begin
          state  <= ST_OUT;
          busy_q <= 1'b0;
          en_q   <= 1'b0;
          a_q    <= pad.dout;
        end
        ST_OUT: begin
          if (!pad.dir_req) begin
            state    <= ST_TURN_IN;
            en_q     <= 1'b1;
            busy_q   <= 1'b1;
            turn_cnt <= 4'(TURN_CYC - 1);
          end else begin
            a_q <= pad.dout;
          end
        end
        ST_TURN_IN: begin
          if (turn_cnt == '0) begin
            state  <= ST_IN;
            busy_q <= 1'b0;
            puen_q <= pull_nxt.puen;
            pden_q <= pull_nxt.pden;
            fill_q <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt - 1'b1;
          end
        end
        default: state <= ST_IN;
      endcase
    end
  end

  pad_in_filter #(.DEB_W(DEB_W)) u_filter (
    .CLK    (CLK),
    .RST    (RST),
    .y      (pad.Y),
    .active (state == ST_IN),
    .din    (din_w)
  );

  // Previous-cycle copies of din and din_valid for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      din_d   <= 1'b0;
      valid_d <= 1'b0;
    end else begin
      din_d   <= din_w;
      valid_d <= valid_q;
    end
  end

  assign pad.A         = a_q;
  assign pad.EN        = en_q;
  assign pad.PUEN      = puen_q;
  assign pad.PDEN      = pden_q;
  assign pad.PI        = 1'b1;
  assign pad.din       = din_w;
  assign pad.din_valid = valid_q;
  assign pad.busy      = busy_q;
  // Both cycles must be valid, so the din_valid 0->1 step never pulses.
  assign pad.rise      = valid_q & valid_d &  din_w & ~din_d;
  assign pad.fall      = valid_q & valid_d & ~din_w &  din_d;

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Scoreboard bench for pad_io_ctrl: the driver applies directed and random
// stimulus, a behavioural model predicts each post-edge output set and
// pushes it to a queue; the monitor pops and compares on the falling edge.
module tb_pad_io_ctrl;

  localparam int TC     = 3;
  localparam int DW     = 4;
  localparam int STABLE = (1 << DW) - 1;

  typedef struct {
    bit a, en, puen, pden, pi, din, valid, rise, fall, busy;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;

  pad_io_ctrl_if pad ();

  pad_io_ctrl #(.TURN_CYC(TC), .DEB_W(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .pad (pad)
  );

  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // Behavioural model: direction granted, remaining turnaround cycles,
  // time spent in input mode, Y sample history.
  bit m_drv;
  int m_turn;
  int m_age;
  int m_run;
  bit m_a, m_puen, m_pden, m_din, m_valid, m_din_prev, m_valid_prev;
  bit y_hist[$];

  task automatic model_edge(input bit r, input bit d, input bit o,
                            input bit [1:0] p, input bit y, output exp_t e);
    bit in_before, in_now, s_before;
    if (r) begin
      m_drv = 0; m_turn = 0; m_age = 0; m_run = 0;
      m_a = 0; m_puen = 1; m_pden = 1; m_din = 0; m_valid = 0;
      m_din_prev = 0; m_valid_prev = 0;
      y_hist = {1'b0, 1'b0};
    end else begin
      in_before = !m_drv && (m_turn == 0);
      s_before  = y_hist[0];
      // Turnarounds run to completion; requests are looked at afterwards.
      if (m_turn > 0)              m_turn--;
      else if (!m_drv && d)  begin m_drv = 1; m_turn = 1;  end
      else if (m_drv && !d)  begin m_drv = 0; m_turn = TC; end
      y_hist.push_back(y);
      void'(y_hist.pop_front());
`ifdef PAD_DEBOUNCE_EN
      if (in_before && (s_before != m_din)) begin
        m_run++;
        if (m_run == STABLE) begin
          m_din = s_before;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
`else
      m_din = y_hist[0];
`endif
      in_now = !m_drv && (m_turn == 0);
      if (in_now) begin
        m_puen = (p != 2'b01);
        m_pden = (p != 2'b10);
        m_age  = in_before ? ((m_age < 2) ? m_age + 1 : 2) : 0;
        m_valid = (m_age >= 2);
      end else begin
        m_puen = 1; m_pden = 1; m_valid = 0; m_age = 0;
      end
      if (m_drv && (m_turn == 0)) m_a = o;
    end
    e.a     = m_a;
    e.en    = !(m_drv && (m_turn == 0));
    e.puen  = m_puen;
    e.pden  = m_pden;
    e.pi    = 1'b1;
    e.din   = m_din;
    e.valid = m_valid;
    e.busy  = (m_turn > 0);
    e.rise  = m_valid && m_valid_prev && m_din && !m_din_prev;
    e.fall  = m_valid && m_valid_prev && !m_din && m_din_prev;
    m_din_prev   = m_din;
    m_valid_prev = m_valid;
  endtask

  task automatic check(input string name, input logic act, input bit exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp_v);
    end
  endtask

  // Apply one cycle of inputs, predict the outcome of the coming edge.
  task automatic drive(input bit r, input bit d, input bit o,
                       input bit [1:0] p, input bit y);
    exp_t e;
    RST          = r;
    pad.dir_req  = d;
    pad.dout     = o;
    pad.pull_sel = p;
    pad.Y        = y;
    model_edge(r, d, o, p, y, e);
    exp_q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  initial begin : driver
    bit       d, o, y;
    bit [1:0] p;
    int       y_left;
    // Reset with a pending output request.
    repeat (2) drive(1, 1, 0, 2'b00, 0);
    // Input mode, pull_sel walk including 11 and 01/10 toggles.
    drive(0, 0, 0, 2'b01, 0);
    drive(0, 0, 0, 2'b01, 0);
    drive(0, 0, 0, 2'b11, 0);
    drive(0, 0, 0, 2'b10, 0);
    drive(0, 0, 0, 2'b01, 0);
    drive(0, 0, 0, 2'b10, 0);
    drive(0, 0, 0, 2'b00, 0);
    // Input to output with dout=1, then some output data.
    drive(0, 1, 1, 2'b01, 0);
    drive(0, 1, 1, 2'b01, 0);
    drive(0, 1, 1, 2'b01, 1);
    drive(0, 1, 0, 2'b01, 1);
    drive(0, 1, 1, 2'b01, 0);
    // Output to input; request flips inside the turnaround are ignored.
    drive(0, 0, 0, 2'b10, 0);
    drive(0, 1, 0, 2'b10, 0);
    drive(0, 0, 0, 2'b10, 0);
    repeat (6) drive(0, 0, 0, 2'b10, 0);
    // Y glitch of 5 cycles, then a long high level, then low again.
    repeat (5)  drive(0, 0, 0, 2'b00, 1);
    repeat (10) drive(0, 0, 0, 2'b00, 0);
    repeat (20) drive(0, 0, 0, 2'b00, 1);
    repeat (20) drive(0, 0, 0, 2'b00, 0);
    // Reset landing in the middle of the input turnaround.
    repeat (4) drive(0, 1, 1, 2'b01, 0);
    drive(0, 0, 1, 2'b01, 0);
    drive(0, 0, 1, 2'b01, 0);
    drive(1, 0, 1, 2'b01, 0);
    repeat (4) drive(0, 0, 0, 2'b01, 1);
    // Random traffic.
    d = 0; p = 2'b00; y = 0; y_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) d = ~d;
      o = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) p = 2'($urandom_range(3));
      if (y_left == 0) begin
        y = ~y;
        y_left = $urandom_range(24, 1);
      end
      y_left--;
      drive($urandom_range(499) == 0, d, o, p, y);
    end
    done = 1'b1;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("A",         pad.A,         e.a);
        check("EN",        pad.EN,        e.en);
        check("PUEN",      pad.PUEN,      e.puen);
        check("PDEN",      pad.PDEN,      e.pden);
        check("PI",        pad.PI,        e.pi);
        check("din",       pad.din,       e.din);
        check("din_valid", pad.din_valid, e.valid);
        check("rise",      pad.rise,      e.rise);
        check("fall",      pad.fall,      e.fall);
        check("busy",      pad.busy,      e.busy);
      end else if (!done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard @%0t: got empty queue expected one entry", $time);
      end
      if (done && (exp_q.size() == 0)) break;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of run expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pad_io_ctrl.md
PAD_IO_CTRL -- requirements
Module: pad_io_ctrl

Interface
REQ-001 SHALL have parameter TURN_CYC, default 2, turnaround cycles between output drive and input sampling (range 1..15).
REQ-002 SHALL have parameter DEB_W, default 4, debounce counter width; required stable time is 2**DEB_W-1 cycles.
REQ-003 SHALL have port CLK  input  1  single rising-edge clock.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port dir_req  input  1  requested direction: 1 = output, 0 = input.
REQ-006 SHALL have port dout  input  1  core data to drive on the pad.
REQ-007 SHALL have port pull_sel  input  2  00 = none, 01 = pull-up, 10 = pull-down, 11 = none.
REQ-008 SHALL have port A  output  1  pad-cell data in.
REQ-009 SHALL have port EN  output  1  pad-cell output enable, active-low (0 = pad driven).
REQ-010 SHALL have port PUEN  output  1  pad-cell pull-up enable, active-low.
REQ-011 SHALL have port PDEN  output  1  pad-cell pull-down enable, active-low.
REQ-012 SHALL have port PI  output  1  NAND-tree input to the pad cell, tied 1 in functional mode.
REQ-013 SHALL have port Y  input  1  asynchronous pad receive data.
REQ-014 SHALL have port din  output  1  synchronized (and filtered) pad value.
REQ-015 SHALL have port din_valid  output  1  din is a valid input sample.
REQ-016 SHALL have port rise, fall  output  1 each  single-cycle edge pulses on din.
REQ-017 SHALL have port busy  output  1  direction turnaround in progress.

Function
REQ-018 SHALL run an FSM with states IN, TURN_OUT, OUT, TURN_IN.
REQ-019 IN: EN=1; pulls per pull_sel; din_valid=1 once the synchronizer has been refilled (2 cycles after entry).
REQ-020 IN with dir_req=1 SHALL go to TURN_OUT: PUEN=PDEN=1, EN=1 for exactly 1 cycle, then OUT.
REQ-021 OUT: EN=0; A=dout registered (1-cycle latency); PUEN=PDEN=1; din_valid=0; rise/fall=0.
REQ-022 OUT with dir_req=0 SHALL go to TURN_IN: EN=1, pulls off, held for TURN_CYC cycles, then IN.
REQ-023 dir_req changes during TURN_* states SHALL be ignored until the state completes; re-evaluation occurs in the destination state.
REQ-024 busy SHALL be 1 exactly in TURN_OUT and TURN_IN.
REQ-025 pull_sel SHALL take effect on PUEN/PDEN one cycle after sampling; PUEN and PDEN SHALL never both be 0.
REQ-026 Y SHALL pass through a 2-flop synchronizer before any use.
REQ-027 rise/fall SHALL pulse for one cycle when din changes while din_valid=1; no pulse on the din_valid 0->1 transition.
REQ-028 PI SHALL be constant 1.

Reset
REQ-029 RST=1 at a clock edge SHALL force: state IN, A=0, EN=1, PUEN=1, PDEN=1, din=0, din_valid=0, rise=fall=0, busy=0, synchronizer and counters cleared.
REQ-030 Reset asserted mid-OUT or mid-turnaround SHALL release the pad (EN=1) on that same edge.

Configuration
REQ-031 With PAD_DEBOUNCE_EN defined: din SHALL update only after the synchronized value has been stable for 2**DEB_W-1 consecutive cycles; counter restarts on any change or on leaving IN.
REQ-032 Without PAD_DEBOUNCE_EN: din SHALL equal the synchronizer output directly; DEB_W unused.

Structure
REQ-033 A shared package pad_io_pkg SHALL hold the FSM state typedef and pull_sel encoding constants.
REQ-034 Synchronizer plus debounce filter SHALL be a sub-module pad_in_filter.

Verification
REQ-035 Reset: RST=1 for 2 cycles with dir_req=1 -> EN=1, PUEN=PDEN=1, busy=0, din_valid=0.
REQ-036 Input to output: IN, dir_req 0->1, dout=1 -> busy=1 for 1 cycle, then EN=0 and A=1; pulls released before EN falls.
REQ-037 Output to input, TURN_CYC=3: dir_req 1->0 -> EN=1 next edge, busy=1 for 3 cycles, pulls restored after, din_valid=1 2 cycles after reaching IN.
REQ-038 Debounce on, DEB_W=4: Y glitches high for 5 cycles -> din stays 0, no rise; Y high for 20 cycles -> din=1 after 15 stable cycles plus 2 sync, one rise pulse.
REQ-039 pull_sel=11 and 01/10 toggling in IN -> PUEN/PDEN never both 0; 01 gives PUEN=0,PDEN=1 one cycle later.
REQ-040 RST asserted in TURN_IN -> EN=1, state IN, busy=0 at that edge.
